// File: rtl/deserializer_if.sv
// Serial-in / word-out bundle between the link endpoint and downstream parallel logic.
// master = deserializer side (drives the word outputs), slave = the environment around it.
interface deserializer_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = $clog2(DATA_W) + 1
);
    logic              ser_data_i;
    logic              ser_data_val_i;
    logic [DATA_W-1:0] deser_data_o;
    logic [LEN_W-1:0]  deser_len_o;
    logic              deser_data_val_o;
    logic              deser_data_ready_i;
    logic              overrun_o;
    logic              busy_o;

    modport master (
        input  ser_data_i, ser_data_val_i, deser_data_ready_i,
        output deser_data_o, deser_len_o, deser_data_val_o, overrun_o, busy_o
    );

    modport slave (
        output ser_data_i, ser_data_val_i, deser_data_ready_i,
        input  deser_data_o, deser_len_o, deser_data_val_o, overrun_o, busy_o
    );
endinterface

// File: rtl/deserializer.sv
// MSB-first serial to left-aligned word; full word valid the cycle after its last bit, partial the cycle after the gap.
// One-entry output register with simultaneous accept/load; a word completing against a held, unaccepted word is dropped and pulses overrun_o.
module deserializer #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = $clog2(DATA_W) + 1
) (
    input  logic           clk_i,
    input  logic           arst_n_i,
    deserializer_if.master bus
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_dat;
    logic [LEN_W-1:0]  r_len;
    logic              r_val;
    logic              r_ovr;

    logic              w_last;
    logic              w_full;
    logic              w_part;
    logic              w_done;
    logic              w_load;
    logic [LEN_W-1:0]  w_shamt;
    logic [DATA_W-1:0] w_word;
    logic [LEN_W-1:0]  w_len;

    assign w_last  = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_full  = bus.ser_data_val_i && w_last;
    assign w_part  = !bus.ser_data_val_i && (r_cnt != '0);
    assign w_done  = w_full || w_part;
    assign w_load  = w_done && (!r_val || bus.deser_data_ready_i);

    // Partial frames hold their cnt bits at the bottom of r_sh; shift them up to the MSB.
    assign w_shamt = LEN_W'(DATA_W) - LEN_W'(r_cnt);
    assign w_word  = w_full ? {r_sh[DATA_W-2:0], bus.ser_data_i} : (r_sh << w_shamt);
    assign w_len   = w_full ? LEN_W'(DATA_W) : LEN_W'(r_cnt);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (bus.ser_data_val_i) begin
            r_sh  <= {r_sh[DATA_W-2:0], bus.ser_data_i};
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end else if (w_part) begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_dat <= '0;
            r_len <= '0;
            r_val <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            r_ovr <= w_done && !w_load;
            if (w_load) begin
                r_dat <= w_word;
                r_len <= w_len;
                r_val <= 1'b1;
            end else if (r_val && bus.deser_data_ready_i) begin
                r_val <= 1'b0;
            end
        end
    end

    assign bus.deser_data_o     = r_dat;
    assign bus.deser_len_o      = r_len;
    assign bus.deser_data_val_o = r_val;
    assign bus.overrun_o        = r_ovr;
    assign bus.busy_o           = (r_cnt != '0);
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: inputs change 1 time unit after a rising edge, outputs checked there too.
module tb_deserializer;
    logic clk_i = 1'b0;
    logic arst_n_i = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic ov_seen;

    deserializer_if #(.DATA_W(16)) bus ();

    deserializer #(.DATA_W(16)) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) begin
            bus.ser_data_i     = w[i];
            bus.ser_data_val_i = 1'b1;
            tick();
            if (bus.overrun_o) ov_seen = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [4:0]  pbits;
        bus.ser_data_i         = 1'b0;
        bus.ser_data_val_i     = 1'b0;
        bus.deser_data_ready_i = 1'b1;
        ov_seen                = 1'b0;

        // Reset state
        #2;
        chk("rst_data", bus.deser_data_o, 32'h0);
        chk("rst_len",  bus.deser_len_o,  32'h0);
        chk("rst_val",  bus.deser_data_val_o, 32'h0);
        chk("rst_ovr",  bus.overrun_o, 32'h0);
        chk("rst_busy", bus.busy_o, 32'h0);
        tick();
        arst_n_i = 1'b1;
        tick();

        // Full word 0xA5C3
        w = 16'hA5C3;
        for (int i = 15; i >= 0; i--) begin
            bus.ser_data_i     = w[i];
            bus.ser_data_val_i = 1'b1;
            tick();
            chk("full_busy", bus.busy_o, (i != 0) ? 32'h1 : 32'h0);
            chk("full_val",  bus.deser_data_val_o, (i == 0) ? 32'h1 : 32'h0);
        end
        chk("full_data", bus.deser_data_o, 32'hA5C3);
        chk("full_len",  bus.deser_len_o, 32'd16);
        bus.ser_data_val_i = 1'b0;
        tick();
        chk("full_accept_val",  bus.deser_data_val_o, 32'h0);
        chk("full_keep_data",   bus.deser_data_o, 32'hA5C3);
        chk("idle_ovr",         bus.overrun_o, 32'h0);

        // Partial frame 1,0,1,1,0
        pbits = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            bus.ser_data_i     = pbits[i];
            bus.ser_data_val_i = 1'b1;
            tick();
        end
        chk("part_val_early", bus.deser_data_val_o, 32'h0);
        chk("part_busy",      bus.busy_o, 32'h1);
        bus.ser_data_val_i = 1'b0;
        tick();
        chk("part_val",  bus.deser_data_val_o, 32'h1);
        chk("part_data", bus.deser_data_o, 32'hB000);
        chk("part_len",  bus.deser_len_o, 32'd5);
        chk("part_busy_end", bus.busy_o, 32'h0);
        tick();
        chk("part_accept_val", bus.deser_data_val_o, 32'h0);

        // Back-to-back 0x1234, 0xFFFF
        ov_seen = 1'b0;
        send_word(16'h1234);
        chk("b2b_w1_data", bus.deser_data_o, 32'h1234);
        chk("b2b_w1_len",  bus.deser_len_o, 32'd16);
        chk("b2b_w1_val",  bus.deser_data_val_o, 32'h1);
        send_word(16'hFFFF);
        chk("b2b_w2_data", bus.deser_data_o, 32'hFFFF);
        chk("b2b_w2_len",  bus.deser_len_o, 32'd16);
        chk("b2b_w2_val",  bus.deser_data_val_o, 32'h1);
        bus.ser_data_val_i = 1'b0;
        tick();
        if (bus.overrun_o) ov_seen = 1'b1;
        chk("b2b_no_ovr", ov_seen, 32'h0);

        // Backpressure: 0x0001 held, 0x8000 dropped
        bus.deser_data_ready_i = 1'b0;
        ov_seen = 1'b0;
        send_word(16'h0001);
        chk("bp_w1_data", bus.deser_data_o, 32'h0001);
        chk("bp_w1_val",  bus.deser_data_val_o, 32'h1);
        send_word(16'h8000);
        chk("bp_ovr_pulse", bus.overrun_o, 32'h1);
        chk("bp_hold_data", bus.deser_data_o, 32'h0001);
        chk("bp_hold_len",  bus.deser_len_o, 32'd16);
        bus.ser_data_val_i = 1'b0;
        tick();
        chk("bp_ovr_end", bus.overrun_o, 32'h0);
        chk("bp_hold_val", bus.deser_data_val_o, 32'h1);
        chk("bp_hold_data2", bus.deser_data_o, 32'h0001);
        bus.deser_data_ready_i = 1'b1;
        tick();
        chk("bp_release_val", bus.deser_data_val_o, 32'h0);

        // Simultaneous accept and load
        bus.deser_data_ready_i = 1'b0;
        send_word(16'h1111);
        chk("sim_w1_data", bus.deser_data_o, 32'h1111);
        w = 16'h2222;
        for (int i = 15; i >= 0; i--) begin
            bus.ser_data_i     = w[i];
            bus.ser_data_val_i = 1'b1;
            if (i == 0) bus.deser_data_ready_i = 1'b1;
            tick();
        end
        chk("sim_data", bus.deser_data_o, 32'h2222);
        chk("sim_val",  bus.deser_data_val_o, 32'h1);
        chk("sim_ovr",  bus.overrun_o, 32'h0);
        bus.ser_data_val_i = 1'b0;
        tick();
        chk("sim_ovr_next", bus.overrun_o, 32'h0);
        chk("sim_accept_val", bus.deser_data_val_o, 32'h0);

        // Async reset mid-frame after 7 bits
        for (int i = 0; i < 7; i++) begin
            bus.ser_data_i     = 1'b1;
            bus.ser_data_val_i = 1'b1;
            tick();
        end
        chk("ar_busy_pre", bus.busy_o, 32'h1);
        #3;
        bus.ser_data_val_i = 1'b0;
        arst_n_i = 1'b0;
        #1;
        chk("ar_data", bus.deser_data_o, 32'h0);
        chk("ar_len",  bus.deser_len_o, 32'h0);
        chk("ar_val",  bus.deser_data_val_o, 32'h0);
        chk("ar_busy", bus.busy_o, 32'h0);
        chk("ar_ovr",  bus.overrun_o, 32'h0);
        #1;
        arst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ser_data_i     = 1'b1;
            bus.ser_data_val_i = 1'b1;
            tick();
        end
        bus.ser_data_val_i = 1'b0;
        tick();
        chk("ar_post_data", bus.deser_data_o, 32'hE000);
        chk("ar_post_len",  bus.deser_len_o, 32'd3);
        chk("ar_post_val",  bus.deser_data_val_o, 32'h1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
